led_scan_seq: RTL and testbench
===============================

Name: led_scan_seq

Overview:
Upstream sequencer for the 1-to-8 LED demultiplexer. It accepts an 8-bit LED pattern through a load strobe and steps the demux select through positions 0..7, presenting the matching pattern bit on the demux data input. Each position is held for a programmable number of clock cycles. It runs one-shot or loops continuously, and reports busy and done to the controlling logic.

Parameters:
DIV, 4, clock cycles each position is held (dwell); legal range DIV >= 1
NPOS, 8, number of demux positions; fixed at 8 to match the 3-bit select
SEL_W, 3, select width; equals log2(NPOS)

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
load  in  1  start strobe; honoured only in IDLE
pattern  in  8  LED pattern; bit k is driven on data while A == k
loop_en  in  1  1 = wrap after position 7 and continue; 0 = one-shot
A  out  3  demux select, registered
data  out  1  demux data bit, registered
busy  out  1  high while scanning
done  out  1  single-cycle pulse when a one-shot scan completes

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. All outputs are registered.
- Reset (rst=1 at an edge) forces state IDLE, A=0, data=0, busy=0, done=0, dwell counter=0, pattern register=0. rst has priority over every other input, including mid-scan: the scan is abandoned and no done pulse is generated.
- States:
  - IDLE: busy=0, A=0, data=0.
  - SCAN: busy=1.
- IDLE -> SCAN: at the edge where load=1.
  - pattern is captured into an internal register.
  - A=0, data=pattern[0], busy=1, dwell counter=0. These are visible the cycle after the load edge.
- SCAN:
  - The dwell counter increments each cycle, from 0 to DIV-1.
  - At the edge where the counter equals DIV-1 and A<7: A increments by 1, data takes the captured pattern[A+1], and the counter clears to 0.
  - Each position therefore holds for exactly DIV cycles.
- End of position 7 (counter=DIV-1, A=7):
  - If loop_en=1 (sampled at this edge): A wraps to 0, data takes captured pattern[0], state stays SCAN, and no done pulse is generated.
  - If loop_en=0: state goes to IDLE, A=0, data=0, busy=0, and done=1 for exactly one cycle.
- One-shot busy duration is exactly 8*DIV cycles. done rises in the same cycle that busy falls.
- load while in SCAN is ignored. The pattern register is not updated and the scan continues unaffected.
- load in the same cycle that done is high (state already IDLE) is accepted, so back-to-back scans have a zero-cycle gap.
- Changes to pattern after capture have no effect until the next accepted load.
- loop_en may change at any time. Only its value at the end of position 7 matters.
- DIV=1: A advances every cycle, and a one-shot scan is busy for 8 cycles.
- Arithmetic:
  - Dwell counter width is clog2(DIV), minimum 1 bit.
  - A is 3 bits and its wrap from 7 to 0 is explicit, not overflow-dependent.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=1'b0, ST_SCAN=1'b1
  - NPOS=8 and SEL_W=3, shared with the demux stage
- One sub-module is natural: tick_div, a dwell counter with parameter DIV.
  - Inputs: clk, rst, clr, en.
  - Output: tick, high when the count equals DIV-1 and en=1.
  - Clears on clr or when it wraps.
- The FSM, select counter and pattern register stay in led_scan_seq.

Test Plan:
1. Reset mid-scan: load pattern=8'hA5, run 10 cycles, assert rst for 1 cycle -> next cycle A=0, data=0, busy=0, done=0; done is never observed high afterwards.
2. One-shot, DIV=4, loop_en=0, load pattern=8'b1010_0101 -> A holds 0,1,...,7 for 4 cycles each; data sequence is 1,0,1,0,0,1,0,1; busy is high for exactly 32 cycles; done pulses for 1 cycle in the cycle busy falls; A=0 and data=0 afterwards.
3. Load ignored while busy: load 8'hFF, then at cycle 5 load 8'h00 -> data stays 1 for all 8 positions; busy length remains 32 cycles.
4. Loop mode: loop_en=1, load 8'h81 -> after A=7 ends, A wraps to 0 with data=1 and no done pulse; deassert loop_en during position 3 of the second pass -> scan ends after that pass's position 7 with a single done pulse.
5. Back-to-back: one-shot scan of 8'h0F, with load=1 and pattern=8'hF0 in the done cycle -> the next cycle has busy=1, A=0, data=0; position 4 of the new scan shows data=1.
6. DIV=1 build: load 8'h55 -> A increments every cycle, 0 through 7; data alternates 1,0,1,0,1,0,1,0; busy is high for 8 cycles; done pulses once.

Source files
------------

// File: rtl/led_scan_seq_pkg.sv
// Shared definitions for the LED scan sequencer and the downstream 1-to-8 demux stage.
package led_scan_seq_pkg;

  localparam int unsigned NPOS  = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/led_scan_seq_if.sv
// Control/data bundle between the scan controller (master) and the sequencer (slave).
interface led_scan_seq_if;

  logic                                  load;
  logic [led_scan_seq_pkg::NPOS-1:0]     pattern;
  logic                                  loop_en;
  logic [led_scan_seq_pkg::SEL_W-1:0]    A;
  logic                                  data;
  logic                                  busy;
  logic                                  done;

  modport master (
    output load,
    output pattern,
    output loop_en,
    input  A,
    input  data,
    input  busy,
    input  done
  );

  modport slave (
    input  load,
    input  pattern,
    input  loop_en,
    output A,
    output data,
    output busy,
    output done
  );

endinterface

// File: rtl/led_scan_seq_tick_div.sv
// Dwell counter: counts 0..DIV-1 while enabled and flags the final count as a tick.
module led_scan_seq_tick_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_scan_seq.sv
// Steps the demux select through all positions, holding each for DIV cycles and driving the
// captured pattern bit for the current position; one-shot or continuous.
module led_scan_seq
  import led_scan_seq_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  led_scan_seq_if.slave   bus
);

  localparam logic [SEL_W-1:0] LastPos = SEL_W'(NPOS - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  a_q, a_d;
  logic              data_q, data_d;
  logic              done_q, done_d;
  logic [NPOS-1:0]   pat_q, pat_d;
  logic              scan;
  logic              tick;

  assign scan = (state_q == ST_SCAN);

  // Counter is held at zero in IDLE so every scan starts with a full dwell.
  led_scan_seq_tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!scan),
    .en_i   (scan),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    data_d  = data_q;
    done_d  = 1'b0;
    pat_d   = pat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          state_d = ST_SCAN;
          pat_d   = bus.pattern;
          a_d     = '0;
          data_d  = bus.pattern[0];
        end
      end
      ST_SCAN: begin
        if (tick) begin
          if (a_q != LastPos) begin
            a_d    = a_q + SEL_W'(1);
            data_d = pat_q[a_d];
          end else if (bus.loop_en) begin
            a_d    = '0;
            data_d = pat_q[0];
          end else begin
            state_d = ST_IDLE;
            a_d     = '0;
            data_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      data_q  <= 1'b0;
      done_q  <= 1'b0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      data_q  <= data_d;
      done_q  <= done_d;
      pat_q   <= pat_d;
    end
  end

  assign bus.A    = a_q;
  assign bus.data = data_q;
  assign bus.busy = scan;
  assign bus.done = done_q;

endmodule

// File: tb/tb_led_scan_seq.sv
// Directed bench for led_scan_seq: a DIV=4 instance for most scenarios, a DIV=1 instance for
// the single-cycle dwell case.
module tb_led_scan_seq;

  logic clk;
  logic rst;

  led_scan_seq_if bus4 ();
  led_scan_seq_if bus1 ();

  led_scan_seq #(.DIV(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  led_scan_seq #(.DIV(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [7:0] pat);
    bus4.load    = 1'b1;
    bus4.pattern = pat;
    step();
    bus4.load    = 1'b0;
  endtask

  logic [7:0] exp_pat;
  int         done_seen;

  initial begin
    rst          = 1'b1;
    bus4.load    = 1'b0;
    bus4.pattern = '0;
    bus4.loop_en = 1'b0;
    bus1.load    = 1'b0;
    bus1.pattern = '0;
    bus1.loop_en = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_A",    32'(bus4.A),    32'd0);
    check("rst_busy", 32'(bus4.busy), 32'd0);
    check("rst_done", 32'(bus4.done), 32'd0);

    // 1. reset mid-scan
    load4(8'hA5);
    check("t1_busy_start", 32'(bus4.busy), 32'd1);
    check("t1_data_start", 32'(bus4.data), 32'd1);
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t1_A",    32'(bus4.A),    32'd0);
    check("t1_data", 32'(bus4.data), 32'd0);
    check("t1_busy", 32'(bus4.busy), 32'd0);
    check("t1_done", 32'(bus4.done), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus4.done) done_seen++;
    end
    check("t1_no_done", 32'(done_seen), 32'd0);

    // 2. one-shot A5
    bus4.loop_en = 1'b0;
    exp_pat = 8'b1010_0101;
    load4(exp_pat);
    for (int i = 0; i < 32; i++) begin
      check("t2_A",    32'(bus4.A),    32'(i / 4));
      check("t2_data", 32'(bus4.data), 32'(exp_pat[i / 4]));
      check("t2_busy", 32'(bus4.busy), 32'd1);
      check("t2_done", 32'(bus4.done), 32'd0);
      step();
    end
    check("t2_end_busy", 32'(bus4.busy), 32'd0);
    check("t2_end_done", 32'(bus4.done), 32'd1);
    check("t2_end_A",    32'(bus4.A),    32'd0);
    check("t2_end_data", 32'(bus4.data), 32'd0);
    step();
    check("t2_done_1cyc", 32'(bus4.done), 32'd0);

    // 3. load ignored while busy
    load4(8'hFF);
    for (int i = 0; i < 32; i++) begin
      check("t3_data", 32'(bus4.data), 32'd1);
      check("t3_busy", 32'(bus4.busy), 32'd1);
      if (i == 5) begin
        bus4.load    = 1'b1;
        bus4.pattern = 8'h00;
      end
      step();
      bus4.load = 1'b0;
    end
    check("t3_end_busy", 32'(bus4.busy), 32'd0);
    check("t3_end_done", 32'(bus4.done), 32'd1);
    step();

    // 4. loop mode, drop loop_en during position 3 of the second pass
    bus4.loop_en = 1'b1;
    exp_pat = 8'h81;
    load4(exp_pat);
    done_seen = 0;
    for (int i = 0; i < 64; i++) begin
      check("t4_A",    32'(bus4.A),    32'((i / 4) % 8));
      check("t4_data", 32'(bus4.data), 32'(exp_pat[(i / 4) % 8]));
      check("t4_busy", 32'(bus4.busy), 32'd1);
      if (bus4.done) done_seen++;
      if (i == 44) bus4.loop_en = 1'b0;
      step();
    end
    check("t4_no_done_loop", 32'(done_seen), 32'd0);
    check("t4_end_busy",     32'(bus4.busy), 32'd0);
    check("t4_end_done",     32'(bus4.done), 32'd1);
    step();
    check("t4_done_1cyc", 32'(bus4.done), 32'd0);

    // 5. back-to-back with load in the done cycle
    load4(8'h0F);
    for (int i = 0; i < 32; i++) step();
    check("t5_done", 32'(bus4.done), 32'd1);
    bus4.load    = 1'b1;
    bus4.pattern = 8'hF0;
    step();
    bus4.load    = 1'b0;
    bus4.pattern = 8'h00;
    check("t5_busy",  32'(bus4.busy), 32'd1);
    check("t5_A",     32'(bus4.A),    32'd0);
    check("t5_data",  32'(bus4.data), 32'd0);
    check("t5_done0", 32'(bus4.done), 32'd0);
    for (int i = 0; i < 16; i++) step();
    check("t5_pos4_A",    32'(bus4.A),    32'd4);
    check("t5_pos4_data", 32'(bus4.data), 32'd1);
    for (int i = 0; i < 16; i++) step();
    check("t5_end_done", 32'(bus4.done), 32'd1);

    // 6. DIV=1 instance
    bus1.load    = 1'b1;
    bus1.pattern = 8'h55;
    step();
    bus1.load    = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      check("t6_A",    32'(bus1.A),    32'(i));
      check("t6_data", 32'(bus1.data), 32'((i % 2) == 0));
      check("t6_busy", 32'(bus1.busy), 32'd1);
      if (bus1.done) done_seen++;
      step();
    end
    check("t6_end_busy", 32'(bus1.busy), 32'd0);
    check("t6_end_done", 32'(bus1.done), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (bus1.done) done_seen++;
      step();
    end
    check("t6_done_once", 32'(done_seen), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
